// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for the Z80 memory bus.
// Each grant runs ACC1, ACC2 (stretched by WAIT_L) and a one-cycle REC gap.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              WAIT_L,
    output logic              MREQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic [ADDR_W-1:0] addr_bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, REC} state_t;

    state_t            state;
    logic              last_gnt;
    logic              op_port;
    logic              op_we;
    logic              drive;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    logic              any_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the port that did not win last time goes next.
    assign any_req   = req0 | req1;
    assign pick      = (req0 && req1) ? ~last_gnt : req1;
    assign sel_we    = pick ? we1 : we0;
    assign sel_addr  = pick ? addr1 : addr0;
    assign sel_wdata = pick ? wdata1 : wdata0;

    assign addr_bus = op_addr;
    assign data_bus = drive ? op_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            op_port  <= 1'b0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            drive    <= 1'b0;
            MREQ_L   <= 1'b1;
            RD_L     <= 1'b1;
            WR_L     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            unique case (state)
                IDLE, REC: begin
                    if (any_req) begin
                        state    <= ACC1;
                        op_port  <= pick;
                        last_gnt <= pick;
                        op_we    <= sel_we;
                        op_addr  <= sel_addr;
                        op_wdata <= sel_wdata;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                        MREQ_L   <= 1'b0;
                        RD_L     <= sel_we;
                        WR_L     <= ~sel_we;
                        drive    <= sel_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC1: state <= ACC2;
                ACC2: begin
                    if (WAIT_L) begin
                        state  <= REC;
                        MREQ_L <= 1'b1;
                        RD_L   <= 1'b1;
                        WR_L   <= 1'b1;
                        drive  <= 1'b0;
                        if (!op_we) begin
                            rdata   <= data_bus;
                            rvalid0 <= ~op_port;
                            rvalid1 <= op_port;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory on the bus.
// A bench-side probe drives 0x99 on data_bus when nobody else should drive.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        WAIT_L = 1'b1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0]  rdata;
    logic        MREQ_L, RD_L, WR_L;
    logic [15:0] addr_bus;
    wire  [7:0]  data_bus;

    logic [7:0]  mem [0:65535];
    logic        probe_en = 1'b0;
    logic        pl_en = 1'b0;
    logic [15:0] pl_a = 0;
    logic [7:0]  pl_d = 0;
    logic        rd_en;

    int nchk = 0;
    int nerr = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst_L(rst_L),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .WAIT_L(WAIT_L),
        .MREQ_L(MREQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .addr_bus(addr_bus), .data_bus(data_bus)
    );

    always #5 clk = ~clk;

    assign rd_en    = !MREQ_L && !RD_L;
    assign data_bus = rd_en ? mem[addr_bus] : (probe_en ? 8'h99 : 8'hzz);

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (!MREQ_L && !WR_L) mem[addr_bus] <= data_bus;
    end

    always @(negedge clk) begin
        if (rst_L) begin
            nchk++;
            if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
                nerr++;
                $display("FAIL overlap: gnt=%b%b rvalid=%b%b required no overlap",
                         gnt0, gnt1, rvalid0, rvalid1);
            end
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic        r1, w1;
        logic [15:0] a1;
        logic [7:0]  d1;
        logic [3:0]  gv;
        logic [2:0]  strb;
        logic [15:0] ab;
        logic [7:0]  rd;
        logic        p;
        logic [7:0]  db;
    } vec_t;

    vec_t vt [11];

    function automatic logic [38:0] obs();
        return {gnt0, gnt1, rvalid0, rvalid1, MREQ_L, RD_L, WR_L,
                addr_bus, rdata, data_bus};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Outputs are sampled 2ns after the edge, probe only during the sample.
    task automatic step_chk(input string nm, input logic p,
                            input logic [38:0] exp);
        @(posedge clk);
        #1 probe_en = p;
        #1 chk(nm, 64'(obs()), 64'(exp));
        probe_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_a = a;
        pl_d = d;
        pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [15:0] a0,
                          input logic [7:0] d0, input logic r1, input logic w1,
                          input logic [15:0] a1, input logic [7:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_L = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_L = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b1000, 3'b001, 16'h0005, 8'h00, 1'b0, 8'h3C};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b001, 16'h0005, 8'h00, 1'b0, 8'h3C};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0010, 3'b111, 16'h0005, 8'h3C, 1'b1, 8'h99};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b111, 16'h0005, 8'h3C, 1'b1, 8'h99};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0010, 8'hA5,
                   4'b0100, 3'b010, 16'h0010, 8'h3C, 1'b0, 8'hA5};
        vt[5]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b010, 16'h0010, 8'h3C, 1'b0, 8'hA5};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b111, 16'h0010, 8'h3C, 1'b1, 8'h99};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h00,
                   4'b0100, 3'b001, 16'h0010, 8'h3C, 1'b0, 8'hA5};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b001, 16'h0010, 8'h3C, 1'b0, 8'hA5};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0001, 3'b111, 16'h0010, 8'hA5, 1'b1, 8'h99};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00,
                   4'b0000, 3'b111, 16'h0010, 8'hA5, 1'b1, 8'h99};

        preload(16'h0005, 8'h3C);
        preload(16'h0020, 8'h77);
        preload(16'h0030, 8'h11);
        do_reset();

        #1 probe_en = 1'b1;
        #1 chk("reset_state", 64'(obs()),
               64'({4'b0000, 3'b111, 16'h0000, 8'h00, 8'h99}));
        probe_en = 1'b0;

        // Single read on port 0, then port 1 write and read-back
        for (int i = 0; i < 11; i++) begin
            set_in(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
                   vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
            step_chk($sformatf("vec%0d", i), vt[i].p,
                     {vt[i].gv, vt[i].strb, vt[i].ab, vt[i].rd, vt[i].db});
        end

        // Continuous tie: grants alternate 0,1,0,1 every third cycle
        do_reset();
        set_in(1, 0, 16'h0005, 0, 1, 0, 16'h0010, 0);
        for (int k = 1; k <= 12; k++) begin
            logic g0, g1, v0, v1;
            g0 = (k % 3 == 1) && ((k / 3) % 2 == 0);
            g1 = (k % 3 == 1) && ((k / 3) % 2 == 1);
            v0 = (k % 3 == 0) && (((k - 2) / 3) % 2 == 0);
            v1 = (k % 3 == 0) && (((k - 2) / 3) % 2 == 1);
            step();
            chk($sformatf("rr_cyc%0d", k), 64'({gnt0, gnt1, rvalid0, rvalid1}),
                64'({g0, g1, v0, v1}));
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Two wait states on a read
        set_in(1, 0, 16'h0020, 0, 0, 0, 0, 0);
        step();
        chk("wait_gnt", 64'({gnt0, MREQ_L, RD_L}), 64'(3'b100));
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        WAIT_L = 1'b0;
        step();
        chk("wait_acc2_a", 64'({rvalid0, MREQ_L, RD_L}), 64'(3'b000));
        step();
        chk("wait_acc2_b", 64'({rvalid0, MREQ_L, RD_L}), 64'(3'b000));
        WAIT_L = 1'b1;
        step();
        chk("wait_rvalid", 64'({rvalid0, rvalid1, MREQ_L, RD_L, rdata}),
            64'({4'b1011, 8'h77}));

        // Reset asserted in ACC2 of a write
        step();
        set_in(1, 1, 16'h0030, 8'hEE, 0, 0, 0, 0);
        step();
        chk("rstw_gnt", 64'({gnt0, MREQ_L, WR_L, data_bus}),
            64'({3'b100, 8'hEE}));
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rstw_acc2", 64'({MREQ_L, WR_L, data_bus}), 64'({2'b00, 8'hEE}));
        rst_L = 1'b0;
        #1 probe_en = 1'b1;
        #1 chk("rstw_abort", 64'(obs()),
               64'({4'b0000, 3'b111, 16'h0000, 8'h00, 8'h99}));
        probe_en = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step_chk($sformatf("rstw_quiet%0d", k), 1'b1,
                     {4'b0000, 3'b111, 16'h0000, 8'h00, 8'h99});
        end
        chk("rstw_mem", 64'(mem[16'h0030] == 8'h11 || mem[16'h0030] == 8'hEE),
            64'(1));

        // Read then write back-to-back on port 0, inputs change after gnt
        set_in(1, 0, 16'h0005, 0, 0, 0, 0, 0);
        step_chk("b2b_rd_acc1", 1'b0,
                 {4'b1000, 3'b001, 16'h0005, 8'h00, 8'h3C});
        set_in(1, 1, 16'h0040, 8'h5A, 0, 0, 0, 0);
        step_chk("b2b_rd_acc2", 1'b0,
                 {4'b0000, 3'b001, 16'h0005, 8'h00, 8'h3C});
        step_chk("b2b_rec", 1'b1,
                 {4'b0010, 3'b111, 16'h0005, 8'h3C, 8'h99});
        step_chk("b2b_wr_acc1", 1'b0,
                 {4'b1000, 3'b010, 16'h0040, 8'h3C, 8'h5A});
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step_chk("b2b_wr_rec", 1'b1,
                 {4'b0000, 3'b111, 16'h0040, 8'h3C, 8'h99});
        chk("b2b_mem", 64'(mem[16'h0040]), 64'(8'h5A));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
